aer_bit_sender: RTL and testbench
=================================

# aer_bit_sender

Clocked transmit front-end of the AER link. It accepts a parallel event address from the neuron-array arbiter over a valid/ready handshake. It then serialises the address MSB-first, one four-phase request per bit, driving the `nought` (bit = 0) or `one` (bit = 1) request line into the downstream per-bit handshake cells. It waits on their shared `ack` before moving to the next bit.

## Interface
- `ADDR_W`, 8: event address width in bits (≥ 2).
- `SYNC_STAGES`, 2: flip-flop depth of the `ack` synchroniser (≥ 2).
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `addr_in` input ADDR_W: event address, sampled on accept.
- `addr_valid` input 1: upstream has an address.
- `addr_ready` output 1: block can accept; accept = `addr_valid && addr_ready` at a rising edge.
- `nought` output 1: registered request, current bit is 0.
- `one` output 1: registered request, current bit is 1.
- `ack` input 1: asynchronous acknowledge from the handshake cells.
- `busy` output 1: a word is in flight.
- `word_done` output 1: one-cycle pulse when the last bit's handshake completes.

## Operation
- FSM states:
  - IDLE: `addr_ready = !ack_s`.
  - REQ: the request for the current bit is high; wait for `ack_s = 1`.
  - REL: both requests are low; wait for `ack_s = 0`.
- `ack_s` is the synchronised `ack`.
- IDLE → REQ on accept:
  - latch `addr_in` into the shift register;
  - load the bit counter with the number of bits to send;
  - raise `nought` or `one` according to the MSB.
- REQ → REL when `ack_s = 1`: drop the request.
- REL, `ack_s = 0`, bits remain: shift left, decrement the counter, go to REQ with the new MSB's request.
- REL, `ack_s = 0`, last bit: pulse `word_done`, go to IDLE.
- `nought` and `one` are never high together and are never high outside REQ.
- `busy` = state ≠ IDLE.
- Reset values: `nought = one = busy = word_done = 0`; shift register and counter = 0; state = IDLE. `addr_ready` goes to 1 once `ack_s` is 0.
- Bit counter width: `$clog2(ADDR_W+2)`; it never wraps below 0.
- `ack_s` rising while in REL, or falling while in REQ, is a protocol error. Ignore it and hold the current state.
- Stuck-high `ack` in IDLE holds `addr_ready` low, so no new word starts until `ack` returns low.
- `reset` asserted mid-word:
  - requests drop asynchronously;
  - the partial word is discarded with no `word_done`.
- `addr_valid` high while busy: ignored. The address is not sampled.

## Timing
- Accept at edge N: request for the MSB is high after edge N.
- `ack` rise seen by the synchroniser at edge M: `ack_s` = 1 after edge M+SYNC_STAGES−1; request drops at the next edge.
- Fall of `ack` is symmetric: the next bit's request rises one edge after `ack_s` falls.
- Minimum per-bit period, with `ack` following the request with zero delay: 2·(SYNC_STAGES+1) cycles.
- `word_done` is high for the cycle after the final `ack_s` fall is sampled. It coincides with IDLE.
- `addr_ready` can be high in that same cycle, so back-to-back words have no idle gap beyond the synchroniser.

## Configuration
- `AER_PARITY_EN` defined:
  - after the ADDR_W address bits, one extra handshake carries the even-parity bit (XOR of the address) on `nought`/`one`;
  - words are ADDR_W+1 handshakes.
- `AER_PARITY_EN` undefined: exactly ADDR_W handshakes. No parity logic is present.

## Structure
- Shared package `aer_pkg`:
  - state enum `aer_tx_state_t` (IDLE, REQ, REL);
  - helper `aer_parity` function;
  - default width constant `AER_ADDR_W = 8`.
- One sub-module: `aer_sync`, a SYNC_STAGES-deep synchroniser for `ack`, reset to 0. It is reused by the receive side.

## Test plan
- ADDR_W=8, address 0xA5, `ack` mirrors whichever request is high after 3 cycles → request sequence one,nought,one,nought,nought,one,nought,one; exactly one `word_done` pulse; `nought`&&`one` never both high.
- Two addresses 0x00 then 0xFF presented back-to-back with `addr_valid` held → eight `nought` handshakes then eight `one` handshakes; second accept happens in the `word_done` cycle.
- `reset` pulsed while the 4th bit's request is high → `nought`=`one`=0 immediately; `busy`=0; no `word_done`; next word 0x3C transmits correctly from its MSB.
- `ack` held high before any word, `addr_valid`=1 → `addr_ready`=0 and no request until `ack` drops; then the word starts within SYNC_STAGES+1 cycles.
- Glitch: `ack` pulsed high for 1 cycle while in REL → ignored; bit count unchanged; word still completes with 8 handshakes.
- With `AER_PARITY_EN`, address 0x07 → 9 handshakes; the ninth is `one` (parity 1). Address 0x03 → ninth is `nought`.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared definitions for the AER link: transmit state encoding, parity helper
// and the default event-address width.
package aer_pkg;

  localparam int AER_ADDR_W = 8;

  // Widest address the parity helper covers; callers zero-extend into it.
  localparam int AER_PARITY_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } aer_tx_state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic aer_parity(input logic [AER_PARITY_MAX_W-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/aer_sync.sv
// Multi-flop synchroniser for an asynchronous handshake line, cleared to 0 on
// reset. Shared by the transmit and receive sides of the AER link.
module aer_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/aer_bit_sender.sv
// AER transmit front-end: accepts a parallel address and sends it MSB-first as
// one four-phase nought/one request per bit. Define AER_PARITY_EN to append an
// even-parity handshake after the address bits.
//
//   state | meaning
//   IDLE  | no word in flight; ready while synchronised ack is low
//   REQ   | request for the current bit is high; waiting for ack_s = 1
//   REL   | both requests low; waiting for ack_s = 0
module aer_bit_sender
  import aer_pkg::*;
#(
  parameter int ADDR_W      = AER_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  output logic              nought,
  output logic              one,
  input  logic              ack,
  output logic              busy,
  output logic              word_done
);

`ifdef AER_PARITY_EN
  localparam int N_BITS = ADDR_W + 1;
`else
  localparam int N_BITS = ADDR_W;
`endif
  localparam int               CNT_W    = $clog2(ADDR_W + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  aer_tx_state_t     state_q, state_d;
  logic [N_BITS-1:0] shift_q, shift_d, load_word;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nought_q, nought_d;
  logic              one_q, one_d;
  logic              word_done_q, word_done_d;
  logic              ack_s;

  aer_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (ack),
    .sync_o  (ack_s)
  );

`ifdef AER_PARITY_EN
  assign load_word = {addr_in, aer_parity(AER_PARITY_MAX_W'(addr_in))};
`else
  assign load_word = addr_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      nought_q    <= 1'b0;
      one_q       <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      nought_q    <= nought_d;
      one_q       <= one_d;
      word_done_q <= word_done_d;
    end
  end

  // Requests default low so they can only be high while the next state is REQ.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    nought_d    = 1'b0;
    one_d       = 1'b0;
    word_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (addr_valid && addr_ready) begin
          shift_d  = load_word;
          cnt_d    = CNT_LOAD;
          one_d    = load_word[N_BITS-1];
          nought_d = !load_word[N_BITS-1];
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = REL;
        end else begin
          nought_d = nought_q;
          one_d    = one_q;
        end
      end
      REL: begin
        if (!ack_s) begin
          if (cnt_q > CNT_ONE) begin
            shift_d  = shift_q << 1;
            cnt_d    = cnt_q - CNT_ONE;
            one_d    = shift_q[N_BITS-2];
            nought_d = !shift_q[N_BITS-2];
            state_d  = REQ;
          end else begin
            cnt_d       = '0;
            word_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign addr_ready = (state_q == IDLE) && !ack_s;
  assign nought     = nought_q;
  assign one        = one_q;
  assign busy       = (state_q != IDLE);
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_aer_bit_sender.sv
// Self-checking bench for aer_bit_sender: directed scenarios plus random words,
// each compared against an address-to-bit-sequence reference.
module tb_aer_bit_sender;

  localparam int SS = 2;
`ifdef AER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr_in;
  logic       addr_valid;
  logic       addr_ready;
  logic       nought;
  logic       one;
  logic       ack;
  logic       busy;
  logic       word_done;

  aer_bit_sender #(
    .ADDR_W      (8),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .nought     (nought),
    .one        (one),
    .ack        (ack),
    .busy       (busy),
    .word_done  (word_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: bits sent MSB-first, optionally followed by even parity.
  function automatic logic [31:0] exp_bits(input logic [7:0] a);
`ifdef AER_PARITY_EN
    return {23'd0, a, ^a};
`else
    return {24'd0, a};
`endif
  endfunction

  // Responder and monitor: ack mirrors the request 'dly' negedges later.
  int          dly       = 3;
  bit          force_en  = 1'b0;
  bit          force_val = 1'b0;
  bit          glitch    = 1'b0;
  logic [7:0]  hist      = '0;
  int          hs_cnt    = 0;
  logic [31:0] hs_bits   = '0;
  int          wd_cnt    = 0;
  int          overlap   = 0;
  int          outside   = 0;
  logic        req_prev  = 1'b0;

  initial begin
    logic req;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      req = nought | one;
      if (nought && one) overlap++;
      if (req && !busy) outside++;
      if (word_done) wd_cnt++;
      if (req && !req_prev) begin
        hs_cnt++;
        hs_bits = {hs_bits[30:0], one};
      end
      req_prev = req;
      if (reset) hist = '0;
      else hist = {hist[6:0], req};
      ack = force_en ? force_val : (hist[dly] | glitch);
    end
  end

  function automatic logic [31:0] mask(input int n);
    return (32'h1 << n) - 32'h1;
  endfunction

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (addr_ready) return;
    end
    check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic start_word(input logic [7:0] a);
    addr_in    = a;
    addr_valid = 1'b1;
    @(posedge clk); #1;
    addr_valid = 1'b0;
  endtask

  // Waits for word_done; returns negedges counted from the accept edge.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (word_done) begin
        check({tag, "_idle_at_done"}, 32'(busy), 32'd0);
        return;
      end
      cycles++;
    end
    check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic finish_word(input string tag, input logic [31:0] exp, input int n,
                             input int h0, input int w0, input int nwd);
    @(negedge clk); #1;
    check({tag, "_count"}, 32'(hs_cnt - h0), 32'(n));
    check({tag, "_bits"}, hs_bits & mask(n), exp & mask(n));
    check({tag, "_word_done"}, 32'(wd_cnt - w0), 32'(nwd));
  endtask

  task automatic run_word(input string tag, input logic [7:0] a);
    int h0, w0, cyc;
    wait_ready(tag);
    h0 = hs_cnt;
    w0 = wd_cnt;
    start_word(a);
    wait_done(tag, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(NB * 2 * (SS + 1 + dly)));
    finish_word(tag, exp_bits(a), NB, h0, w0, 1);
  endtask

  initial begin
    int h0, w0, cyc, bad;
    logic [7:0] a;

    reset      = 1'b1;
    addr_valid = 1'b0;
    addr_in    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {28'd0, nought, one, busy, word_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("reset_ready", 32'(addr_ready), 32'd1);

    dly = 3;
    run_word("a5", 8'hA5);

    // Back-to-back: valid held across the word_done cycle.
    repeat (8) @(negedge clk);
    wait_ready("b2b");
    h0 = hs_cnt;
    w0 = wd_cnt;
    addr_in    = 8'h00;
    addr_valid = 1'b1;
    @(posedge clk); #1;
    addr_in = 8'hFF;
    wait_done("b2b_first", cyc);
    check("b2b_ready_in_done", 32'(addr_ready), 32'd1);
    @(posedge clk); #1;
    addr_valid = 1'b0;
    check("b2b_second_accepted", 32'(busy), 32'd1);
    wait_done("b2b_second", cyc);
    finish_word("b2b", (exp_bits(8'h00) << NB) | exp_bits(8'hFF), 2 * NB, h0, w0, 2);

    // Reset while the fourth request is high.
    repeat (8) @(negedge clk);
    wait_ready("rst_mid");
    h0 = hs_cnt;
    w0 = wd_cnt;
    start_word(8'hC3);
    bad = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if ((hs_cnt - h0) >= 4 && (nought || one)) begin
        bad = 0;
        break;
      end
    end
    check("rst_mid_reached", 32'(bad), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_requests", {30'd0, nought, one}, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("rst_mid_no_done", 32'(wd_cnt - w0), 32'd0);
    run_word("after_rst", 8'h3C);

    // Stuck-high ack in IDLE blocks the next word.
    repeat (8) @(negedge clk);
    #1;
    force_val = 1'b1;
    force_en  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    h0 = hs_cnt;
    w0 = wd_cnt;
    addr_in    = 8'h5A;
    addr_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (addr_ready || nought || one || busy) bad++;
    end
    check("stuck_hold", 32'(bad), 32'd0);
    force_val = 1'b0;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      cyc++;
      if (busy) break;
    end
    addr_valid = 1'b0;
    force_en   = 1'b0;
    check("stuck_start_delay_ok", 32'((cyc - 1) <= SS + 1 && busy), 32'd1);
    wait_done("stuck", cyc);
    finish_word("stuck", exp_bits(8'h5A), NB, h0, w0, 1);

    // Extra ack pulse in REL merged with the release: no lost or extra bit.
    repeat (8) @(negedge clk);
    wait_ready("glitch");
    h0 = hs_cnt;
    w0 = wd_cnt;
    start_word(8'h96);
    bad = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if ((hs_cnt - h0) == 3 && !(nought || one)) begin
        bad = 0;
        break;
      end
    end
    check("glitch_reached_rel", 32'(bad), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    glitch = 1'b1;
    @(negedge clk); #1;
    glitch = 1'b0;
    wait_done("glitch", cyc);
    finish_word("glitch", exp_bits(8'h96), NB, h0, w0, 1);

    // Parity-relevant addresses and the fastest responder.
    repeat (8) @(negedge clk);
    #1;
    dly = 0;
    run_word("p07_fast", 8'h07);
    repeat (8) @(negedge clk);
    run_word("p03_fast", 8'h03);

    for (int k = 0; k < 20; k++) begin
      repeat (8 + $urandom_range(0, 5)) @(negedge clk);
      #1;
      dly = int'($urandom_range(0, 4));
      a   = 8'($urandom);
      run_word("rand", a);
    end

    check("never_both_high", 32'(overlap), 32'd0);
    check("no_request_when_idle", 32'(outside), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
